// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through to writeback, or runs one
// load/store over a req/ack data-memory port while stalling the upstream stages.
module mem_stage #(
    parameter int ARQ     = 16,
    parameter int RD_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic [RD_W-1:0] rd_in,
    input  logic [ARQ-1:0]  alu_result,
    input  logic [ARQ-1:0]  srcdest,
    input  logic            flush,
    output logic            stall,
    output logic            dm_req,
    output logic            dm_we,
    output logic [ARQ-1:0]  dm_addr,
    output logic [ARQ-1:0]  dm_wdata,
    input  logic [ARQ-1:0]  dm_rdata,
    input  logic            dm_ack,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [RD_W-1:0] wb_rd,
    output logic [ARQ-1:0]  wb_data,
    output logic            err
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    localparam int CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_load_q;
    logic            rw_q;
    logic            squash_q;
    logic [RD_W-1:0] rd_q;

    logic            dm_req_q, dm_we_q;
    logic [ARQ-1:0]  dm_addr_q, dm_wdata_q;
    logic            wb_valid_q, wb_reg_write_q;
    logic [RD_W-1:0] wb_rd_q;
    logic [ARQ-1:0]  wb_data_q;
    logic            err_q;

    logic is_mem_op, is_illegal, kill;

    assign cnt_d      = cnt_q + CW'(1);
    assign is_illegal = mem_read & mem_write;
    assign is_mem_op  = mem_read ^ mem_write;
    // A flush arriving on the ack edge still squashes the register write.
    assign kill       = squash_q | flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            is_load_q      <= 1'b0;
            rw_q           <= 1'b0;
            squash_q       <= 1'b0;
            rd_q           <= '0;
            dm_req_q       <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_addr_q      <= '0;
            dm_wdata_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in && !flush) begin
                        if (is_illegal) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_in;
                            wb_data_q  <= alu_result;
                            err_q      <= 1'b1;
                        end else if (is_mem_op) begin
                            is_load_q  <= mem_read;
                            rw_q       <= reg_write & ~mem_write;
                            rd_q       <= rd_in;
                            squash_q   <= 1'b0;
                            cnt_q      <= '0;
                            dm_req_q   <= 1'b1;
                            dm_we_q    <= mem_write;
                            dm_addr_q  <= alu_result;
                            dm_wdata_q <= srcdest;
                            state_q    <= WAIT_ACK;
                        end else begin
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= reg_write;
                            wb_rd_q        <= rd_in;
                            wb_data_q      <= alu_result;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (dm_ack) begin
                        dm_req_q       <= 1'b0;
                        state_q        <= IDLE;
                        wb_valid_q     <= 1'b1;
                        wb_reg_write_q <= rw_q & ~kill;
                        wb_rd_q        <= rd_q;
                        wb_data_q      <= is_load_q ? dm_rdata : dm_addr_q;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: retire the instruction without a register write.
                        dm_req_q   <= 1'b0;
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= dm_addr_q;
                        err_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                        if (flush) squash_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall        = (state_q == WAIT_ACK);
    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wdata     = dm_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected writeback bundles,
// a negedge monitor pops and compares each wb_valid pulse.
module tb_mem_stage;

    logic        clk, rst;
    logic        valid_in, mem_read, mem_write, reg_write, flush;
    logic [3:0]  rd_in;
    logic [15:0] alu_result, srcdest;
    logic        stall, dm_req, dm_we;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack;
    logic        wb_valid, wb_reg_write;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rw;
        logic [3:0]  rd;
        logic [15:0] data;
        logic        err;
        bit          full;
    } exp_t;
    exp_t exp_q[$];

    mem_stage #(.ARQ(16), .RD_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .rd_in(rd_in),
        .alu_result(alu_result), .srcdest(srcdest), .flush(flush),
        .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [3:0] rd, input logic [15:0] d,
                        input logic e, input bit full);
        exp_t x;
        x.rw = rw; x.rd = rd; x.data = d; x.err = e; x.full = full;
        exp_q.push_back(x);
    endtask

    // Drive one instruction for a single cycle; returns at the negedge after capture.
    task automatic issue(input logic mr, input logic mw, input logic rw,
                         input logic [3:0] rd, input logic [15:0] alu, input logic [15:0] sd);
        @(negedge clk);
        valid_in = 1'b1; mem_read = mr; mem_write = mw; reg_write = rw;
        rd_in = rd; alu_result = alu; srcdest = sd;
        @(negedge clk);
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    endtask

    // Ack on the coming edge; returns at the negedge after it.
    task automatic ack(input logic [15:0] d);
        dm_ack = 1'b1; dm_rdata = d;
        @(negedge clk);
        dm_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("wb err", 32'(err), 32'(e.err));
                if (e.full) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", 32'(wb_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        rst = 1'b0; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b0; flush = 1'b0; rd_in = '0; alu_result = '0;
        srcdest = '0; dm_rdata = '0; dm_ack = 1'b0;
        #3;
        chk("reset dm_req", 32'(dm_req), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset wb_valid", 32'(wb_valid), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ALU pass-through
        push(1'b1, 4'd3, 16'd650, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 1'b1, 4'd3, 16'd650, 16'd0);
        chk("pass stall", 32'(stall), 32'd0);
        chk("pass dm_req", 32'(dm_req), 32'd0);

        // Load acked after 3 cycles
        issue(1'b1, 1'b0, 1'b1, 4'd5, 16'd1500, 16'd0);
        for (int i = 0; i < 3; i++) begin
            chk("load dm_req", 32'(dm_req), 32'd1);
            chk("load dm_addr", 32'(dm_addr), 32'd1500);
            chk("load stall", 32'(stall), 32'd1);
            chk("load dm_we", 32'(dm_we), 32'd0);
            if (i < 2) @(negedge clk);
        end
        push(1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1);
        ack(16'hBEEF);
        chk("load done dm_req", 32'(dm_req), 32'd0);
        chk("load done stall", 32'(stall), 32'd0);

        // Store acked after 1 cycle; reg_write forced low
        issue(1'b0, 1'b1, 1'b1, 4'd7, 16'd400, 16'd300);
        chk("store dm_we", 32'(dm_we), 32'd1);
        chk("store dm_wdata", 32'(dm_wdata), 32'd300);
        chk("store dm_addr", 32'(dm_addr), 32'd400);
        push(1'b0, 4'd7, 16'd400, 1'b0, 1'b1);
        ack(16'h0000);
        chk("store done dm_req", 32'(dm_req), 32'd0);

        // Flush while waiting squashes the register write
        issue(1'b1, 1'b0, 1'b1, 4'd2, 16'd100, 16'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush stall", 32'(stall), 32'd1);
        push(1'b0, 4'd2, 16'h1234, 1'b0, 1'b1);
        ack(16'h1234);

        // Illegal op: both read and write
        push(1'b0, 4'd4, 16'd55, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 1'b1, 4'd4, 16'd55, 16'd0);
        chk("illegal err", 32'(err), 32'd1);
        chk("illegal dm_req", 32'(dm_req), 32'd0);
        chk("illegal stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("err sticky", 32'(err), 32'd1);

        // Reset mid-transfer clears outputs without a clock edge
        issue(1'b1, 1'b0, 1'b1, 4'd1, 16'd77, 16'd0);
        chk("pre-reset dm_req", 32'(dm_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async rst dm_req", 32'(dm_req), 32'd0);
        chk("async rst stall", 32'(stall), 32'd0);
        chk("async rst wb_valid", 32'(wb_valid), 32'd0);
        chk("async rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Load after reset proceeds normally
        issue(1'b1, 1'b0, 1'b1, 4'd9, 16'd2000, 16'd0);
        chk("post-rst dm_req", 32'(dm_req), 32'd1);
        chk("post-rst dm_addr", 32'(dm_addr), 32'd2000);
        push(1'b1, 4'd9, 16'h0A5A, 1'b0, 1'b1);
        ack(16'h0A5A);

        // Timeout: 4 cycles in WAIT_ACK, then abort
        issue(1'b1, 1'b0, 1'b1, 4'd6, 16'd300, 16'd0);
        push(1'b0, 4'd6, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("timeout dm_req held", 32'(dm_req), 32'd1);
            @(negedge clk);
        end
        chk("timeout dm_req", 32'(dm_req), 32'd0);
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout stall", 32'(stall), 32'd0);

        // Late ack ignored
        ack(16'hFFFF);
        chk("late ack wb_valid", 32'(wb_valid), 32'd0);
        chk("late ack dm_req", 32'(dm_req), 32'd0);
        chk("late ack stall", 32'(stall), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
